// File: rtl/leb128_decoder_pkg.sv
// Shared definitions for the LEB128 immediate decoder: FSM encoding,
// maximum encoded lengths and the final-byte padding masks.
package leb128_decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int LEB128_MAX32 = 5;
    localparam int LEB128_MAX64 = 10;

    // Payload bits of the last permitted byte that lie beyond the target width
    // (for signed variants the mask also covers the target's own sign bit).
    localparam logic [6:0] PAD_MASK_U32 = 7'h70;
    localparam logic [6:0] PAD_MASK_S32 = 7'h78;
    localparam logic [6:0] PAD_MASK_U64 = 7'h7E;
    localparam logic [6:0] PAD_MASK_S64 = 7'h7F;

endpackage

// File: rtl/leb128_decoder_pad_check.sv
// Combinational check that the payload of a max-length final byte carries
// only zero (unsigned) or sign-replicated (signed) bits above the target width.
module leb128_decoder_pad_check
    import leb128_decoder_pkg::*;
(
    input  logic [6:0] payload,
    input  logic       is_signed,
    input  logic       is64,
    output logic       ok
);

    logic [6:0] mask;
    logic [6:0] masked;

    always_comb begin
        mask = 7'h00;
        case ({is64, is_signed})
            2'b00:   mask = PAD_MASK_U32;
            2'b01:   mask = PAD_MASK_S32;
            2'b10:   mask = PAD_MASK_U64;
            default: mask = PAD_MASK_S64;
        endcase
        masked = payload & mask;
        ok     = is_signed ? ((masked == 7'h00) || (masked == mask)) : (masked == 7'h00);
    end

endmodule

// File: rtl/leb128_decoder.sv
// Byte-serial LEB128 immediate decoder: accumulates 7-bit groups from the
// ROM byte stream and presents a 64-bit value, byte count and error flag.
module leb128_decoder
    import leb128_decoder_pkg::*;
#(
    parameter bit ERR_CHECK_PAD = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_signed,
    input  logic        in_is64,
    output logic [63:0] out_value,
    output logic [3:0]  out_len,
    output logic        out_error,
    output logic        out_valid,
    input  logic        out_ready
);

    state_t      state, state_nxt;
    logic [63:0] acc_p0;
    logic [6:0]  shift_p0;
    logic [3:0]  count_p0;
    logic        signed_p0;
    logic        is64_p0;

    logic        accept;
    logic        first;
    logic        sg_cur;
    logic        w64_cur;
    logic [63:0] acc_nxt;
    logic [6:0]  shift_nxt;
    logic [3:0]  count_nxt;
    logic        at_max;
    logic        last;
    logic        pad_ok;
    logic        err_nxt;
    logic [63:0] val_nxt;

    // Replicate bit (nbits-1) upward; widths of 64 or more need no extension.
    function automatic logic [63:0] sign_extend(input logic [63:0] v, input logic [6:0] nbits);
        logic [63:0] hi_mask;
        logic [5:0]  msb;
        if (nbits >= 7'd64) begin
            return v;
        end
        hi_mask = ~64'd0 << nbits;
        msb     = 6'(nbits - 7'd1);
        return v[msb] ? (v | hi_mask) : (v & ~hi_mask);
    endfunction

    function automatic logic [63:0] finalize(input logic [63:0] v, input logic [6:0] nbits,
                                             input logic sg, input logic w64);
        logic [63:0] t;
        t = v;
        if (sg) begin
            t = sign_extend(v, nbits);
            if (!w64) begin
                t = sign_extend(t, 7'd32);
            end
        end else if (!w64) begin
            t = {32'd0, v[31:0]};
        end
        return t;
    endfunction

    leb128_decoder_pad_check u_pad_check (
        .payload   (in_data[6:0]),
        .is_signed (sg_cur),
        .is64      (w64_cur),
        .ok        (pad_ok)
    );

    always_comb begin
        in_ready  = !reset && (state != ST_DONE);
        out_valid = (state == ST_DONE);
        accept    = in_valid && in_ready;
        first     = (state == ST_IDLE);
        sg_cur    = first ? in_signed : signed_p0;
        w64_cur   = first ? in_is64   : is64_p0;

        if (first) begin
            acc_nxt   = {57'd0, in_data[6:0]};
            shift_nxt = 7'd7;
            count_nxt = 4'd1;
        end else begin
            acc_nxt   = acc_p0 | ({57'd0, in_data[6:0]} << shift_p0);
            shift_nxt = shift_p0 + 7'd7;
            count_nxt = count_p0 + 4'd1;
        end

        at_max  = (count_nxt == (w64_cur ? 4'(LEB128_MAX64) : 4'(LEB128_MAX32)));
        last    = !in_data[7] || at_max;
        err_nxt = at_max && (in_data[7] || (ERR_CHECK_PAD && !pad_ok));
        val_nxt = finalize(acc_nxt, shift_nxt, sg_cur, w64_cur);

        state_nxt = state;
        case (state)
            ST_IDLE, ST_ACCUM: begin
                if (accept) begin
                    state_nxt = last ? ST_DONE : ST_ACCUM;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Stage p0: control state and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            signed_p0 <= 1'b0;
            is64_p0   <= 1'b0;
            out_value <= 64'd0;
            out_len   <= 4'd0;
            out_error <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept && first) begin
                signed_p0 <= in_signed;
                is64_p0   <= in_is64;
            end
            if (accept && last) begin
                out_value <= err_nxt ? 64'd0 : val_nxt;
                out_len   <= count_nxt;
                out_error <= err_nxt;
            end
        end
    end

    // Stage p0: accumulator datapath, rewritten by every first byte
    always_ff @(posedge clk) begin
        if (accept) begin
            acc_p0   <= acc_nxt;
            shift_p0 <= shift_nxt;
            count_p0 <= count_nxt;
        end
    end

endmodule

// File: tb/tb_leb128_decoder.sv
// Bench for leb128_decoder: two instances (pad check on/off) share stimulus
// and are compared against an arithmetic LEB128 reference model.
module tb_leb128_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_signed;
    logic        in_is64;
    logic        out_ready;

    logic        in_ready_p, in_ready_n;
    logic [63:0] out_value_p, out_value_n;
    logic [3:0]  out_len_p, out_len_n;
    logic        out_error_p, out_error_n;
    logic        out_valid_p, out_valid_n;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    leb128_decoder #(.ERR_CHECK_PAD(1'b1)) dut_p (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_p), .in_signed(in_signed), .in_is64(in_is64),
        .out_value(out_value_p), .out_len(out_len_p), .out_error(out_error_p),
        .out_valid(out_valid_p), .out_ready(out_ready)
    );

    leb128_decoder #(.ERR_CHECK_PAD(1'b0)) dut_n (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_n), .in_signed(in_signed), .in_is64(in_is64),
        .out_value(out_value_n), .out_len(out_len_n), .out_error(out_error_n),
        .out_valid(out_valid_n), .out_ready(out_ready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: sum the 7-bit groups as an integer, interpret it as an
    // N*7-bit two's-complement number when signed, then range-check it.
    function automatic void ref_decode(input logic [7:0] b[10], input bit sg, input bit w64,
                                       input bit pad, output logic [63:0] v,
                                       output logic [3:0] n, output bit e);
        int                 mx;
        int                 k;
        int                 bits;
        int                 w;
        bit                 term;
        bit                 fits;
        logic [127:0]       big;
        logic signed [127:0] sv;
        logic signed [127:0] lim;
        mx   = w64 ? 10 : 5;
        w    = w64 ? 64 : 32;
        big  = '0;
        k    = 0;
        term = 1'b0;
        for (int i = 0; i < mx; i++) begin
            big = big | (128'(b[i][6:0]) << (7 * i));
            k   = i + 1;
            if (!b[i][7]) begin
                term = 1'b1;
                break;
            end
        end
        bits = 7 * k;
        sv   = $signed(big);
        if (sg && big[bits-1]) sv = sv - (128'sd1 <<< bits);
        lim  = 128'sd1 <<< (w - 1);
        fits = sg ? ((sv >= -lim) && (sv < lim)) : ((big >> w) == 128'd0);
        n    = 4'(k);
        e    = !term || (pad && (k == mx) && !fits);
        if (e)        v = 64'd0;
        else if (w64) v = sv[63:0];
        else if (sg)  v = {{32{sv[31]}}, sv[31:0]};
        else          v = {32'd0, big[31:0]};
    endfunction

    task automatic run_txn(input string tag, input logic [7:0] b[10], input bit sg,
                           input bit w64, input int hold, input bit gaps);
        logic [63:0] v1, v0;
        logic [3:0]  n1, n0;
        bit          e1, e0;
        int          budget;
        ref_decode(b, sg, w64, 1'b1, v1, n1, e1);
        ref_decode(b, sg, w64, 1'b0, v0, n0, e0);
        for (int i = 0; i < int'(n1); i++) begin
            @(negedge clk);
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            in_data   = b[i];
            in_valid  = 1'b1;
            in_signed = (i == 0) ? sg  : 1'($urandom);
            in_is64   = (i == 0) ? w64 : 1'($urandom);
            budget = 0;
            while (!(in_ready_p && in_ready_n) && budget < 20) begin
                @(negedge clk);
                budget++;
            end
            if (budget >= 20) begin
                chk({tag, " in_ready timeout"}, {in_ready_p, in_ready_n}, 2'b11);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, " out_valid latency p"}, out_valid_p, 1'b1);
        chk({tag, " out_valid latency n"}, out_valid_n, 1'b1);
        chk({tag, " in_ready in done"}, in_ready_p, 1'b0);
        chk({tag, " value p"}, out_value_p, v1);
        chk({tag, " len p"}, out_len_p, n1);
        chk({tag, " error p"}, out_error_p, e1);
        chk({tag, " value n"}, out_value_n, v0);
        chk({tag, " len n"}, out_len_n, n0);
        chk({tag, " error n"}, out_error_n, e0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, " hold valid"}, out_valid_p, 1'b1);
            chk({tag, " hold value"}, out_value_p, v1);
            chk({tag, " hold len"}, out_len_p, n1);
            chk({tag, " hold in_ready"}, in_ready_n, 1'b0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, " valid drop p"}, out_valid_p, 1'b0);
        chk({tag, " valid drop n"}, out_valid_n, 1'b0);
        chk({tag, " ready after"}, in_ready_p, 1'b1);
    endtask

    initial begin
        logic [7:0] b[10];
        bit         sg, w64;
        int         mx, n;

        reset = 1'b1; in_data = 8'h00; in_valid = 1'b0;
        in_signed = 1'b0; in_is64 = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("reset in_ready", in_ready_p, 1'b0);
        chk("reset out_valid", out_valid_p, 1'b0);
        chk("reset out_value", out_value_p, 64'd0);
        chk("reset out_len", out_len_p, 4'd0);
        chk("reset out_error", out_error_p, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        chk("post-reset in_ready", in_ready_p, 1'b1);

        b = '{0:8'hE5, 1:8'h8E, 2:8'h26, default:8'h00};
        run_txn("u32 E5 8E 26", b, 1'b0, 1'b0, 0, 1'b0);
        b = '{0:8'hC0, 1:8'hBB, 2:8'h78, default:8'h00};
        run_txn("s32 C0 BB 78", b, 1'b1, 1'b0, 0, 1'b0);
        b = '{0:8'h7F, default:8'h00};
        run_txn("s64 7F", b, 1'b1, 1'b1, 0, 1'b0);
        run_txn("u64 7F", b, 1'b0, 1'b1, 0, 1'b0);
        b = '{default:8'h80};
        run_txn("u32 overlong", b, 1'b0, 1'b0, 0, 1'b0);
        b = '{0:8'hFF, 1:8'hFF, 2:8'hFF, 3:8'hFF, 4:8'h7F, default:8'h00};
        run_txn("u32 pad FF..7F", b, 1'b0, 1'b0, 0, 1'b0);
        run_txn("s32 pad FF..7F", b, 1'b1, 1'b0, 0, 1'b0);
        b = '{9:8'h7F, default:8'hFF};
        run_txn("s64 10-byte -1", b, 1'b1, 1'b1, 0, 1'b0);
        b = '{9:8'h01, default:8'h80};
        run_txn("u64 bit63", b, 1'b0, 1'b1, 0, 1'b0);
        b = '{9:8'h02, default:8'h80};
        run_txn("u64 bit64 pad", b, 1'b0, 1'b1, 0, 1'b0);
        b = '{0:8'hE5, 1:8'h8E, 2:8'h26, default:8'h00};
        run_txn("backpressure", b, 1'b0, 1'b0, 3, 1'b0);
        b = '{0:8'h2A, default:8'h00};
        run_txn("after bubble 2A", b, 1'b0, 1'b0, 0, 1'b0);

        // Abandon a sequence part-way through with reset.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_data = 8'h80; in_valid = 1'b1; in_signed = 1'b0; in_is64 = 1'b0;
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midreset in_ready", in_ready_p, 1'b0);
        chk("midreset out_valid", out_valid_p, 1'b0);
        chk("midreset out_value", out_value_p, 64'd0);
        chk("midreset out_len", out_len_p, 4'd0);
        chk("midreset out_error", out_error_n, 1'b0);
        reset = 1'b0;
        b = '{0:8'h2A, default:8'h00};
        run_txn("post-reset 2A", b, 1'b0, 1'b0, 0, 1'b0);

        for (int t = 0; t < 60; t++) begin
            sg  = 1'($urandom);
            w64 = 1'($urandom);
            mx  = w64 ? 10 : 5;
            n   = $urandom_range(1, mx);
            for (int i = 0; i < 10; i++) b[i] = 8'($urandom);
            for (int i = 0; i < n - 1; i++) b[i][7] = 1'b1;
            if ($urandom_range(0, 7) != 0) b[n-1][7] = 1'b0;
            if (n == mx && $urandom_range(0, 1) == 1)
                b[n-1] = $urandom_range(0, 1) ? (b[n-1] & 8'h01) : 8'h7F;
            run_txn("random", b, sg, w64, $urandom_range(0, 2), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/leb128_decoder.md
Name: leb128_decoder

Overview:
- Byte-serial LEB128 immediate decoder sitting directly upstream of the cpu decode/execute stage.
- Consumes the instruction byte stream fetched from ROM after an opcode that carries an immediate (br/br_if label depth, i32.const, i64.const, local index, ...).
- Delivers a 64-bit decoded value plus the encoded byte count, so the fetch PC advances correctly.
- Handles signed/unsigned and 32/64-bit variants, and flags malformed encodings so the cpu can raise a trap.

Parameters:
- ERR_CHECK_PAD, 1: when 1, check the unused high bits of the final byte (wasm rule); when 0, ignore them.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- in_data  input  8  next ROM byte
- in_valid  input  1  in_data valid
- in_ready  output  1  decoder accepts byte this cycle
- in_signed  input  1  signed variant; sampled with the first byte only
- in_is64  input  1  64-bit variant; sampled with the first byte only
- out_value  output  64  decoded value (i32 results sign-/zero-extended to 64)
- out_len  output  4  bytes consumed, 1..10
- out_error  output  1  malformed encoding; out_value forced to 0
- out_valid  output  1  result available
- out_ready  input  1  cpu consumes result

Behaviour:
- States: IDLE, ACCUM, DONE.
  - Reset (any state, including mid-sequence) → IDLE.
  - Reset values: in_ready=0 during the reset cycle, then 1; out_valid=0, out_value=0, out_len=0, out_error=0.
  - Partial accumulation is discarded on reset.
- Byte handshake: a byte is accepted when in_valid && in_ready. in_ready=1 in IDLE/ACCUM, 0 in DONE.
- IDLE accept:
  - Latch signed/is64.
  - acc = byte[6:0]; shift=7; count=1.
  - byte[7]=1 → ACCUM, else finalize.
- ACCUM accept:
  - acc |= byte[6:0] << shift; shift+=7; count++.
  - Continue while byte[7]=1.
  - Bits shifted beyond bit 63 are dropped.
- Max bytes: 5 (32-bit), 10 (64-bit). If the byte at the max position has bit7=1 → finalize with error.
- Pad check (ERR_CHECK_PAD=1), applied to a final byte at the max position:
  - u32: byte[6:4]==0.
  - s32: byte[6:3] all equal.
  - u64: byte[6:1]==0.
  - s64: byte[6:0] all 0 or all 1.
  - Violation → error.
- Finalize, registered; out_valid rises the cycle after the last byte is accepted:
  - Signed: sign-extend from bit (shift-1), then for 32-bit re-extend from bit 31.
  - Unsigned 32: zero bits 63:32.
  - Error: out_value=0, out_error=1, out_len=bytes consumed.
  - → DONE.
- DONE:
  - Outputs stable while out_valid && !out_ready.
  - On out_ready → IDLE with out_valid=0 next cycle.
  - One bubble cycle between results; no byte is accepted in the same cycle as the result handshake.
- in_valid gaps in ACCUM: hold state; no timeout.
- Latency: N-byte encoding → out_valid at cycle N+1 after the first byte is accepted with continuous in_valid; throughput N+2 cycles per immediate.

Decomposition:
- Shared header leb128.vh:
  - State encodings (IDLE/ACCUM/DONE).
  - LEB128_MAX32=5, LEB128_MAX64=10.
  - Pad-check masks.
  - Included alongside cpu.vh.
- Optional combinational sub-module leb128_pad_check (final byte, signed, is64 → ok). All sequential logic stays in leb128_decoder.

Test Plan:
- u32 E5 8E 26 → out_value=624485 (0x98765), out_len=3, out_error=0, out_valid asserted cycle 4.
- s32 C0 BB 78 → out_value=0xFFFFFFFFFFFE1DC0 (-123456), out_len=3. s64 7F → all ones, len 1. u64 7F → 127.
- u32 80 80 80 80 80 → out_error=1, out_value=0, out_len=5; in_ready low after 5th byte.
- Pad check, ERR_CHECK_PAD=1:
  - u32 FF FF FF FF 7F → out_error=1.
  - s32 FF FF FF FF 7F → out_value=all ones, no error.
  - With ERR_CHECK_PAD=0, u32 FF FF FF FF 7F → 0xFFFFFFFF, no error.
- Backpressure: out_ready held low 3 cycles after result → out_value/out_len/out_valid stable, in_ready=0; out_ready high → next byte 2A accepted after bubble → 42, len 1.
- Reset after accepting 80 80 → outputs cleared; then 2A → out_value=42, out_len=1, no error.
